// File: rtl/master_bus_pkg.sv
// Shared definitions for the master/slave serial bus ports.
package master_bus_pkg;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 8;
  localparam int BURST_W_DEF = 4;

  typedef enum logic [1:0] {IDLE, WAIT_READY, SEND, DONE} state_e;
endpackage

// File: rtl/piso_shift.sv
// Parallel-load, shift-right register; bit 0 is the serial output.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_d,
  output logic         o_q0
);
  logic [W-1:0] r_sr;

  // Load wins over shift so a burst word can replace the spent one in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sr <= '0;
    else if (i_load)  r_sr <= i_d;
    else if (i_shift) r_sr <= {1'b0, r_sr[W-1:1]};
  end

  assign o_q0 = r_sr[0];
endmodule

// File: rtl/master_out_port.sv
// Master-side bus transmitter: latches a transaction and serialises address/data LSB first.
module master_out_port
  import master_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int BURST_WIDTH = BURST_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_write,
  input  logic [ADDR_WIDTH-1:0]  address_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   slave_ready,
  output logic                   tx_address,
  output logic                   tx_data,
  output logic                   master_valid,
  output logic                   write_en,
  output logic                   read_en,
  output logic                   tx_burst,
  output logic                   data_req,
  output logic                   busy,
  output logic                   done
);
  localparam int DMAX = DATA_WIDTH * (2 ** BURST_WIDTH);
  localparam int MAXB = (ADDR_WIDTH > DMAX) ? ADDR_WIDTH : DMAX;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e                 r_state, w_next;
  logic                   r_op;
  logic [BURST_WIDTH-1:0] r_burst;
  logic [CW-1:0]          r_len, r_k;
  logic [BURST_WIDTH:0]   r_word;
  logic [BW-1:0]          r_wbit;

  logic          w_start_go, w_in_send, w_word_end, w_more_words, w_data_act;
  logic          w_req, w_last, w_addr_q0, w_data_q0;
  logic [CW-1:0] w_data_bits, w_len_in;

  assign w_start_go   = (r_state == IDLE) && start;
  assign w_in_send    = (r_state == SEND);
  assign w_word_end   = (r_wbit == BW'(DATA_WIDTH - 1));
  assign w_more_words = (r_word < {1'b0, r_burst});
  assign w_data_act   = r_op && (r_word <= {1'b0, r_burst});
  assign w_req        = w_in_send && r_op && w_word_end && w_more_words;
  assign w_last       = (r_k == r_len - CW'(1));

  // Write length covers whichever of address or data bits runs longer.
  assign w_data_bits = CW'(DATA_WIDTH) * (CW'(burst_len) + CW'(1));
  assign w_len_in    = (op_write && (w_data_bits > CW'(ADDR_WIDTH))) ? w_data_bits
                                                                     : CW'(ADDR_WIDTH);

  piso_shift #(.W(ADDR_WIDTH)) u_addr_sr (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_start_go),
    .i_shift(w_in_send),
    .i_d    (address_in),
    .o_q0   (w_addr_q0)
  );

  piso_shift #(.W(DATA_WIDTH)) u_data_sr (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_start_go | w_req),
    .i_shift(w_in_send),
    .i_d    (data_in),
    .o_q0   (w_data_q0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= 1'b0;
      r_burst <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_word  <= '0;
      r_wbit  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_go) begin
        r_op    <= op_write;
        r_burst <= burst_len;
        r_len   <= w_len_in;
        r_k     <= '0;
        r_word  <= '0;
        r_wbit  <= '0;
      end else if (w_in_send) begin
        r_k    <= r_k + CW'(1);
        r_wbit <= w_word_end ? '0 : r_wbit + BW'(1);
        // Counts one past the final word so data gating stops cleanly.
        if (w_word_end && w_data_act) r_word <= r_word + (BURST_WIDTH + 1)'(1);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    tx_address   = 1'b0;
    tx_data      = 1'b0;
    master_valid = 1'b0;
    write_en     = 1'b0;
    read_en      = 1'b0;
    tx_burst     = 1'b0;
    data_req     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = WAIT_READY;
      WAIT_READY: begin
        busy     = 1'b1;
        write_en = r_op;
        read_en  = ~r_op;
        tx_burst = |r_burst;
        if (slave_ready) w_next = SEND;
      end
      SEND: begin
        busy         = 1'b1;
        master_valid = 1'b1;
        write_en     = r_op;
        read_en      = ~r_op;
        tx_burst     = |r_burst;
        tx_address   = (r_k < CW'(ADDR_WIDTH)) ? w_addr_q0 : 1'b0;
        tx_data      = w_data_act ? w_data_q0 : 1'b0;
        data_req     = w_req;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: doc/master_out_port.md
Name: master_out_port

Overview:
- Master-side bus transmitter that sits directly upstream of slave_in_port.
- Takes a parallel transaction from the master core (address, write data, read/write op, burst length) and serialises it onto the bus, LSB first.
- Address goes on tx_address and data goes on tx_data. Qualifiers drive master_valid, write_en, read_en and tx_burst.
- Waits for slave_ready before shifting; requests further data words from the core during burst writes.

Parameters:
- ADDR_WIDTH, 12, width of the serialised address.
- DATA_WIDTH, 8, width of one serialised data word.
- BURST_WIDTH, 4, width of burst_len; a burst carries up to 2^BURST_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle transaction request; sampled only in IDLE.
- op_write  in  1  1 = write transaction, 0 = read transaction; latched with start.
- address_in  in  ADDR_WIDTH  target address; latched with start.
- data_in  in  DATA_WIDTH  write word; latched with start and again on every data_req cycle.
- burst_len  in  BURST_WIDTH  number of extra words (0 = single transfer); latched with start.
- slave_ready  in  1  slave can accept a transaction.
- tx_address  out  1  serial address bit.
- tx_data  out  1  serial data bit.
- master_valid  out  1  tx lines carry valid bits this cycle.
- write_en  out  1  write transaction in progress.
- read_en  out  1  read transaction in progress.
- tx_burst  out  1  burst transaction in progress.
- data_req  out  1  one-cycle request for the next burst word.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse when the transaction completes.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - State goes to IDLE.
  - Every output is 0.
  - Counters and shift registers are cleared.
  - Reset asserted mid-transfer aborts the transfer immediately; no done pulse is issued.
- IDLE:
  - start = 1 latches op_write, address_in, data_in and burst_len, then goes to WAIT_READY on the next edge.
  - start = 0 stays in IDLE.
- WAIT_READY:
  - busy = 1; write_en/read_en follow the latched op; tx_burst = (latched burst_len != 0).
  - slave_ready = 1 moves to SEND on the next edge; otherwise holds.
  - slave_ready is ignored once SEND is entered.
- SEND (bit cycle counter k starts at 0):
  - master_valid = 1.
  - tx_address = addr_sr[0] while k < ADDR_WIDTH, else 0.
  - Write: tx_data = data_sr[0]. Read: tx_data = 0.
  - Both shift registers shift right once per cycle.
  - Write, last bit of a word with words remaining: data_req = 1 that cycle. data_in is loaded into data_sr at that edge, so the next word starts the next cycle with no gap.
  - Length, write: max(ADDR_WIDTH, DATA_WIDTH*(burst_len+1)) cycles. Data stops after the final word; tx_data = 0 if address bits remain.
  - Length, read: ADDR_WIDTH cycles.
  - After the last bit cycle, go to DONE.
- DONE:
  - done = 1 for one cycle; tx lines, master_valid, write_en, read_en and tx_burst return to 0.
  - Then go to IDLE; busy = 0 in IDLE.
- start while busy = 1 is ignored.
- Counter widths: the bit counter is wide enough for DATA_WIDTH*2^BURST_WIDTH; the word counter is BURST_WIDTH+1 bits. Neither wraps.

Decomposition:
- Shared package master_bus_pkg holds:
  - the state encoding (IDLE, WAIT_READY, SEND, DONE);
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - slave_in_port uses the same package.
- One natural sub-module, piso_shift (parameterised-width parallel-load, shift-right register, bit0 out):
  - instantiated once for the address;
  - instantiated once for the data.

Test Plan:
- Single write:
  - Stimulus: address_in = 0xADD, data_in = 0xBD, op_write = 1, slave_ready = 1.
  - Response: tx_address = 1,0,1,1,1,0,1,1,0,1,0,1 over 12 cycles; tx_data = 1,0,1,1,1,1,0,1 then 0.
  - master_valid and write_en high for 12 cycles; done 1 cycle later.
- Ready stall:
  - Stimulus: slave_ready held 0 for 5 cycles after start.
  - Response: no master_valid; busy = 1; shifting begins the cycle after slave_ready rises.
- Read:
  - Stimulus: op_write = 0, address_in = 0x123.
  - Response: read_en = 1, tx_data = 0, 12 address bits 1,1,0,0,0,1,0,0,1,0,0,0; data_req never pulses.
- Burst write:
  - Stimulus: burst_len = 2; data_in = 0x01, then 0xFF and 0x80 supplied on data_req cycles.
  - Response: tx_burst = 1, 24 shift cycles, data_req pulses on cycles 7 and 15, serial data matches the three words.
- Mid-transfer reset:
  - Stimulus: reset = 0 at shift cycle 4.
  - Response: all outputs 0 immediately, no done, next start runs normally.
- Busy start:
  - Stimulus: start pulsed during SEND.
  - Response: ignored; latched address and data unchanged.
